// File: rtl/router_input_ctrl.sv
// Ring-link input controller: two VC buffers (even/odd), link side writes VC polarity,
// internal side requests VC ~polarity. Optional accepted-packet counter under PKT_CNT_EN.
module router_input_ctrl #(
    parameter int DW      = 64,
    parameter int HOP_LSB = 48,
    parameter int VC_BIT  = 63
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic          si,
    output logic          ri,
    input  logic [DW-1:0] di,
    output logic          req_fwd,
    input  logic          ack_fwd,
    output logic          req_loc,
    input  logic          ack_loc,
    output logic [DW-1:0] dout,
    output logic          vc_err
`ifdef PKT_CNT_EN
    ,
    output logic [15:0]   pkt_cnt
`endif
);

    // Handshakes: link side transfers on si & ri at posedge (ri never depends on si);
    // internal side completes when the asserted req sees its own ack at posedge.
    logic          even_full, odd_full;
    logic [DW-1:0] even_buf, odd_buf;

    logic          link_fire;
    logic          link_ok;
    logic          int_full;
    logic [DW-1:0] int_buf;
    logic [7:0]    hop;
    logic          int_done;

    assign ri        = polarity ? ~odd_full : ~even_full;
    assign link_fire = si & ri;
    assign link_ok   = link_fire & (di[VC_BIT] == polarity);

    // Internal side always looks at the VC the link side is not touching.
    assign int_full = polarity ? even_full : odd_full;
    assign int_buf  = polarity ? even_buf  : odd_buf;
    assign hop      = int_buf[HOP_LSB +: 8];

    always_comb begin
        req_fwd = 1'b0;
        req_loc = 1'b0;
        dout    = '0;
        if (int_full) begin
            dout = int_buf;
            if (hop == 8'd0) begin
                req_loc = 1'b1;
            end else begin
                req_fwd              = 1'b1;
                dout[HOP_LSB +: 8]   = hop - 8'd1;
            end
        end
    end

    assign int_done = (req_fwd & ack_fwd) | (req_loc & ack_loc);

    always_ff @(posedge clk) begin
        if (reset) begin
            even_full <= 1'b0;
            odd_full  <= 1'b0;
            even_buf  <= '0;
            odd_buf   <= '0;
            vc_err    <= 1'b0;
        end else begin
            vc_err <= link_fire & (di[VC_BIT] != polarity);
            if (polarity) begin
                if (link_ok) begin
                    odd_buf  <= di;
                    odd_full <= 1'b1;
                end
                if (int_done) even_full <= 1'b0;
            end else begin
                if (link_ok) begin
                    even_buf  <= di;
                    even_full <= 1'b1;
                end
                if (int_done) odd_full <= 1'b0;
            end
        end
    end

`ifdef PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)        pkt_cnt <= 16'd0;
        else if (link_ok) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed bench for router_input_ctrl; polarity is driven by the bench and toggled each cycle.
module tb_router_input_ctrl;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          si;
    logic          ri;
    logic [DW-1:0] di;
    logic          req_fwd, ack_fwd, req_loc, ack_loc;
    logic [DW-1:0] dout;
    logic          vc_err;
`ifdef PKT_CNT_EN
    logic [15:0]   pkt_cnt;
`endif

    int passed = 0;
    int total  = 0;

    router_input_ctrl #(.DW(DW), .HOP_LSB(48), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .si(si), .ri(ri), .di(di),
        .req_fwd(req_fwd), .ack_fwd(ack_fwd),
        .req_loc(req_loc), .ack_loc(ack_loc),
        .dout(dout), .vc_err(vc_err)
`ifdef PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: edge, then polarity toggles, then outputs settle.
    task automatic cycle();
        @(posedge clk);
        #1 polarity = ~polarity;
        #1;
    endtask

    initial begin
        reset = 1'b1; polarity = 1'b0; si = 1'b0; di = '0;
        ack_fwd = 1'b0; ack_loc = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ri", ri, 1);
        check("rst_req_fwd", req_fwd, 0);
        check("rst_req_loc", req_loc, 0);
        check("rst_dout", dout, 0);
        check("rst_vc_err", vc_err, 0);
`ifdef PKT_CNT_EN
        check("rst_pkt_cnt", pkt_cnt, 0);
`endif
        reset = 1'b0;

        // VC0 packet with hop 3, forwarded with hop 2
        si = 1'b1; di = 64'h0003_0000_0000_00AB;
        cycle();
        si = 1'b0;
        check("fwd_req", req_fwd, 1);
        check("fwd_req_loc", req_loc, 0);
        check("fwd_dout", dout, 64'h0002_0000_0000_00AB);
        check("fwd_ri_odd", ri, 1);
        ack_fwd = 1'b1;
        cycle();
        ack_fwd = 1'b0;
        check("odd_empty_req", req_fwd, 0);
        cycle();
        check("fwd_cleared", req_fwd, 0);
        check("fwd_cleared_dout", dout, 0);

        // VC1 packet with hop 0, local eject
        si = 1'b1; di = 64'h8000_1234_5678_9ABC;
        cycle();
        si = 1'b0;
        check("loc_req", req_loc, 1);
        check("loc_req_fwd", req_fwd, 0);
        check("loc_dout", dout, 64'h8000_1234_5678_9ABC);
        ack_fwd = 1'b1;
        cycle();
        ack_fwd = 1'b0;
        check("loc_even_side", req_loc, 0);
        cycle();
        check("loc_wrong_ack_kept", req_loc, 1);
        check("loc_wrong_ack_dout", dout, 64'h8000_1234_5678_9ABC);
        ack_loc = 1'b1;
        cycle();
        ack_loc = 1'b0;
        cycle();
        check("loc_cleared", req_loc, 0);

        // Full even buffer back-pressures the link
        si = 1'b1; di = 64'h0005_0000_0000_00CC;
        cycle();
        si = 1'b0;
        check("bp_req", req_fwd, 1);
        check("bp_dout", dout, 64'h0004_0000_0000_00CC);
        cycle();
        check("bp_ri", ri, 0);
        si = 1'b1; di = 64'h0007_0000_0000_00DD;
        cycle();
        si = 1'b0;
        check("bp_dout_kept", dout, 64'h0004_0000_0000_00CC);
        check("bp_no_err", vc_err, 0);
`ifdef PKT_CNT_EN
        check("bp_cnt", pkt_cnt, 3);
`endif
        ack_fwd = 1'b1;
        cycle();
        ack_fwd = 1'b0;
        check("bp_ri_free", ri, 1);

        // Wrong VC id at polarity 0
        si = 1'b1; di = 64'h8000_0000_0000_00EE;
        cycle();
        si = 1'b0;
        check("err_pulse", vc_err, 1);
        check("err_no_write", req_fwd, 0);
`ifdef PKT_CNT_EN
        check("err_cnt", pkt_cnt, 3);
`endif
        cycle();
        check("err_pulse_end", vc_err, 0);
        check("err_ri", ri, 1);

        // Drain even while writing odd on the same edge
        si = 1'b1; di = 64'h0001_0000_0000_00F1;
        cycle();
        check("sim_fwd", req_fwd, 1);
        check("sim_fwd_dout", dout, 64'h0000_0000_0000_00F1);
        ack_fwd = 1'b1; di = 64'h8000_0000_0000_0011;
        cycle();
        ack_fwd = 1'b0; si = 1'b0;
        check("sim_odd_req", req_loc, 1);
        check("sim_odd_dout", dout, 64'h8000_0000_0000_0011);
        check("sim_even_ri", ri, 1);
`ifdef PKT_CNT_EN
        check("sim_cnt", pkt_cnt, 5);
`endif
        cycle();
        check("sim_even_drained", req_fwd | req_loc, 0);
        cycle();
        ack_loc = 1'b1;
        cycle();

`ifdef PKT_CNT_EN
        // Stream hop-0 packets, one per cycle, up to the counter wrap
        for (int i = 0; i < 65530; i++) begin
            si = 1'b1; di = {polarity, 63'h0};
            cycle();
        end
        si = 1'b0;
        check("cnt_ffff", pkt_cnt, 16'hFFFF);
        cycle();
        si = 1'b1; di = {polarity, 63'h0};
        cycle();
        si = 1'b0;
        check("cnt_wrap", pkt_cnt, 16'h0000);
`endif
        ack_loc = 1'b0;

        // Reset mid-operation discards buffered packets
        si = 1'b1; di = {polarity, 15'h0, 48'h77};
        cycle();
        si = 1'b0;
        check("pre_rst_req", req_loc, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_req", req_fwd | req_loc, 0);
        cycle();
        check("mid_rst_req2", req_fwd | req_loc, 0);
        check("mid_rst_ri", ri, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/router_input_ctrl.md
Name: router_input_ctrl

Overview:
- Receiving end of the router-to-router ring link: accepts 64-bit packets from the upstream neighbour's output controller on the si/ri/di handshake.
- Stores each packet in one of two virtual-channel (VC) buffers, even or odd.
- Presents buffered packets to the local output controllers as req/ack requests: ring-forward or local PE eject.
- Polarity alternates even/odd VC use between link side and internal side, so the link never reads and writes the same buffer in one cycle.

Parameters:
- DW, 64, packet width.
- HOP_LSB, 48, LSB of 8-bit hop-count field (bits HOP_LSB+7:HOP_LSB).
- VC_BIT, 63, bit index holding the packet's VC id (0 = even, 1 = odd).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- polarity  in  1  global phase; toggles every cycle after reset
- si  in  1  upstream send strobe; di valid
- ri  out  1  ready to upstream
- di  in  DW  packet from upstream
- req_fwd  out  1  request to ring-forward output ctrl
- ack_fwd  in  1  grant from ring-forward output ctrl
- req_loc  out  1  request to local-eject output ctrl
- ack_loc  in  1  grant from local-eject output ctrl
- dout  out  DW  packet presented with req_*
- vc_err  out  1  one-cycle pulse: si with wrong VC id
- pkt_cnt  out  16  accepted-packet count (only with PKT_CNT_EN)

Behaviour:
- State: even_buf/odd_buf (DW regs), even_full/odd_full flags.
- Reset (sync, active-high, one edge):
  - both full flags and both buffers cleared;
  - vc_err = 0; pkt_cnt = 0.
  - Combinational outputs after reset: ri = 1, req_fwd = req_loc = 0, dout = 0.
- Link side, VC p = polarity:
  - ri = ~full[p], combinational.
  - At posedge with si & ri & di[VC_BIT]==p: buf[p] <= di, full[p] <= 1.
  - si & ri & di[VC_BIT]!=p: packet dropped, vc_err = 1 next cycle.
  - si while ri = 0: ignored, no error; upstream must hold and retry.
- Internal side, VC q = ~polarity:
  - If full[q]:
    - hop == 0 → req_loc = 1, dout = buf[q] unchanged.
    - hop != 0 → req_fwd = 1, dout = buf[q] with hop field decremented by 1, mod-256 arithmetic, other bits unchanged.
  - Exactly one of req_fwd/req_loc high, or neither when empty.
  - At posedge, if the asserted req's matching ack is high: full[q] <= 0. Buffer contents are kept (don't-care).
  - Ack on the non-requesting line, or with no req: ignored.
- Both sides run in the same cycle on different VCs; no interaction.
- Latency: packet accepted at edge n, polarity toggling → req visible in cycle n+1.
- Unacked packet stays; it re-requests every other cycle, whenever its VC is the internal side.
- All req/dout/ri are combinational from registers + polarity; no combinational path from ack to req.
- Reset mid-operation: buffered packets discarded, no req after reset edge.

Optional Feature:
- Macro: PKT_CNT_EN.
- Defined: pkt_cnt port exists; increments by 1 on each accepted link write, wraps at 0xFFFF→0, cleared by reset, not incremented on vc_err drops.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles → ri=1, req_fwd=req_loc=0, dout=0, vc_err=0; pkt_cnt=0 when enabled.
- polarity=0, si=1, di=0x00_03_...AB (VC0, hop 3) → next cycle (polarity=1) req_fwd=1, dout hop=0x02, payload AB. ack_fwd=1 → even_full cleared, req_fwd=0 two cycles later.
- VC1 packet with hop 0 accepted at polarity=1 → req_loc=1 at polarity=0, dout equals di exactly. ack_fwd=1 (wrong line) → no clear; ack_loc=1 → cleared.
- Fill even buffer, no ack → at next polarity=0, ri=0; si with new packet ignored, buffer unchanged, pkt_cnt unchanged.
- si at polarity=0 with di[63]=1 → vc_err pulse 1 cycle, no buffer write, ri stays 1.
- Simultaneous: even buffer drained via ack at polarity=1 while odd packet written same edge → both succeed. With PKT_CNT_EN, pkt_cnt starting at 0xFFFF wraps to 0.
